// File: rtl/vga_fb_scheduler.sv
// Frame-buffer arbiter: keeps the VGA prefetch FIFO ahead of scan-out and
// grants the single memory port to the writer whenever the FIFO is not urgent.
module vga_fb_scheduler #(
  parameter int unsigned H_DISP     = 800,
  parameter int unsigned V_DISP     = 600,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned PIX_W      = 24,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LOW_WM     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              underflow_clr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  localparam int unsigned N_PIX = H_DISP * V_DISP;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

  logic [PIX_W-1:0]  r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_reads_done;
  logic              r_underflow;

  logic [CNT_W-1:0]  w_occ;
  logic              w_read_ok;
  logic              w_urgent;
  logic              w_active;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_uf_set;
  logic              w_rd_issue;
  logic              w_wr_issue;

  // Occupancy counts the read still in flight so its return always has a slot.
  assign w_occ     = r_count + CNT_W'(r_inflight);
  assign w_read_ok = ~r_reads_done & (w_occ < CNT_W'(FIFO_DEPTH));
  assign w_urgent  = w_occ < CNT_W'(LOW_WM);
  assign w_active  = rst_n & ~frame_start;
  assign w_empty   = (r_count == '0);
  assign w_push    = r_inflight & ~frame_start;
  assign w_pop     = pix_pop & ~w_empty & ~frame_start;
  assign w_uf_set  = pix_pop & w_empty & ~frame_start;

  assign pix_valid = ~w_empty;
  assign pix_data  = w_empty ? '0 : r_fifo[r_rd_ptr];
  assign underflow = r_underflow;

  // Port arbitration: urgent prefetch, then writer, then opportunistic prefetch.
  always_comb begin
    wr_ready   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    w_rd_issue = 1'b0;
    w_wr_issue = 1'b0;
    if (w_active) begin
      if (w_urgent & w_read_ok) begin
        w_rd_issue = 1'b1;
      end else begin
        wr_ready = 1'b1;
        if (wr_valid)       w_wr_issue = 1'b1;
        else if (w_read_ok) w_rd_issue = 1'b1;
      end
    end
    if (w_rd_issue) begin
      mem_en   = 1'b1;
      mem_addr = r_rd_addr;
    end else if (w_wr_issue) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_inflight   <= 1'b0;
      r_rd_addr    <= '0;
      r_reads_done <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_uf_set)           r_underflow <= 1'b1;
      else if (underflow_clr) r_underflow <= 1'b0;

      if (frame_start) begin
        // Flush drops any returning read along with the queued pixels.
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_inflight   <= 1'b0;
        r_rd_addr    <= '0;
        r_reads_done <= 1'b0;
      end else begin
        r_inflight <= w_rd_issue;
        if (w_rd_issue) begin
          if (r_rd_addr == LAST_ADDR) begin
            r_rd_addr    <= '0;
            r_reads_done <= 1'b1;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push & ~w_pop)      r_count <= r_count + CNT_W'(1);
        else if (~w_push & w_pop) r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Bench for vga_fb_scheduler: bench-side RAM plus a queue-based model of the
// scan-out stream, with randomized writer and consumer traffic.
module tb_vga_fb_scheduler;

  localparam int unsigned H     = 16;
  localparam int unsigned V     = 12;
  localparam int unsigned N     = H * V;
  localparam int unsigned AW    = 19;
  localparam int unsigned PW    = 24;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LWM   = 4;

  logic          clk = 1'b0;
  logic          rst_n, frame_start, pix_pop, underflow_clr, wr_valid;
  logic [PW-1:0] pix_data, wr_data, mem_wdata, mem_rdata;
  logic          pix_valid, underflow, wr_ready, mem_en, mem_we;
  logic [AW-1:0] wr_addr, mem_addr;

  always #5 clk = ~clk;

  vga_fb_scheduler #(
    .H_DISP(H), .V_DISP(V), .ADDR_W(AW), .PIX_W(PW),
    .FIFO_DEPTH(DEPTH), .LOW_WM(LWM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_pop(pix_pop),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
    .underflow_clr(underflow_clr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Frame-buffer RAM driven by the DUT, one-cycle read latency
  logic [PW-1:0] ram  [512];
  logic [PW-1:0] gold [512];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[8:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[8:0]];
    end
  end

  // Reference model: pixel queue, outstanding read, scan address, sticky flag
  logic [PW-1:0] q [$];
  bit            m_inf, m_done, m_uf;
  logic [PW-1:0] m_inf_val;
  int            m_rd, n_pop;

  logic          e_en, e_we, e_rdy, e_pv, e_uf, o_en, o_we, o_rdy, o_pv, o_uf;
  logic [AW-1:0] e_addr, o_addr;
  logic [PW-1:0] e_wd, e_pd, o_wd, o_pd;
  logic [71:0]   e_vec, o_vec;
  int            checks, failures;

  task automatic tick(input bit rst, input bit fs, input bit pop, input bit wv,
                      input bit clr, input logic [AW-1:0] wa, input logic [PW-1:0] wd);
    int occ;
    bit rok, urg, e_rd, uf_set;
    rst_n = rst; frame_start = fs; pix_pop = pop; wr_valid = wv;
    underflow_clr = clr; wr_addr = wa; wr_data = wd;
    #1;
    occ = q.size() + int'(m_inf);
    rok = !m_done && occ < int'(DEPTH);
    urg = occ < int'(LWM);
    e_rd = 0; e_en = 0; e_we = 0; e_rdy = 0; e_addr = '0; e_wd = '0;
    if (rst && !fs) begin
      if (urg && rok) e_rd = 1;
      else begin
        e_rdy = 1;
        if (wv) begin e_en = 1; e_we = 1; e_addr = wa; e_wd = wd; end
        else if (rok) e_rd = 1;
      end
    end
    if (e_rd) begin e_en = 1; e_addr = AW'(m_rd); end
    e_pv = q.size() > 0;
    e_pd = e_pv ? q[0] : '0;
    e_uf = m_uf;
    o_en = mem_en; o_we = mem_en & mem_we;
    o_addr = mem_en ? mem_addr : '0;
    o_wd = (mem_en & mem_we) ? mem_wdata : '0;
    o_rdy = wr_ready; o_pv = pix_valid; o_pd = pix_data; o_uf = underflow;
    e_vec = {e_en, e_we, e_addr, e_wd, e_rdy, e_pv, e_pd, e_uf};
    o_vec = {o_en, o_we, o_addr, o_wd, o_rdy, o_pv, o_pd, o_uf};
    @(posedge clk);
    if (!rst) begin
      q.delete(); m_inf = 0; m_rd = 0; m_done = 0; m_uf = 0;
    end else begin
      uf_set = !fs && pop && q.size() == 0;
      if (!fs && pop && q.size() > 0) begin void'(q.pop_front()); n_pop++; end
      if (uf_set) m_uf = 1; else if (clr) m_uf = 0;
      if (fs) begin
        q.delete(); m_inf = 0; m_rd = 0; m_done = 0;
      end else begin
        if (m_inf) q.push_back(m_inf_val);
        m_inf = e_rd;
        if (e_rd) begin
          m_inf_val = gold[m_rd];
          if (m_rd == int'(N) - 1) begin m_rd = 0; m_done = 1; end
          else m_rd++;
        end
        if (e_we) gold[wa[8:0]] = wd;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 1, 1, 0, 19'h55, 24'h123456);
      checks++;
      if (o_vec !== e_vec) begin
        failures++; $display("FAIL reset_cycle%0d got=%h exp=%h", i, o_vec, e_vec);
      end
    end
    checks++;
    if ({mem_en, mem_we, pix_valid, pix_data, underflow} !== 28'h0) begin
      failures++;
      $display("FAIL reset_outputs got en=%b we=%b pv=%b pd=%h uf=%b exp all 0",
               mem_en, mem_we, pix_valid, pix_data, underflow);
    end
  endtask

  task automatic test_prefill();
    int reads = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 0, 0, 0, '0, '0);
      checks++;
      if (o_vec !== e_vec) begin
        failures++; $display("FAIL prefill cyc=%0d got=%h exp=%h", i, o_vec, e_vec);
      end
      if (i < 16) begin
        checks++;
        if (!(o_en && !o_we && o_addr == AW'(i))) begin
          failures++; $display("FAIL prefill_addr cyc=%0d got en=%b addr=%0d exp addr=%0d", i, o_en, o_addr, i);
        end
      end
      if (o_en && !o_we) reads++;
    end
    checks++;
    if (reads != 16 || pix_valid !== 1'b1 || pix_data !== gold[0]) begin
      failures++;
      $display("FAIL prefill_full got reads=%0d pv=%b pd=%h exp reads=16 pv=1 pd=%h", reads, pix_valid, pix_data, gold[0]);
    end
  endtask

  task automatic test_write_full();
    int writes = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 1, 0, 19'h100, 24'hFF0000);
      checks++;
      if (o_vec !== e_vec || o_rdy !== 1'b1 || o_we !== 1'b1) begin
        failures++; $display("FAIL write_full cyc=%0d got=%h exp=%h", i, o_vec, e_vec);
      end
      if (o_en && o_we) writes++;
    end
    checks++;
    if (writes != 4 || ram[9'h100] !== 24'hFF0000) begin
      failures++; $display("FAIL write_count got writes=%0d ram=%h exp 4 ff0000", writes, ram[9'h100]);
    end
  endtask

  task automatic test_urgent();
    bit forced = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1, 0, i < 16, 1, 0, AW'(256 + $urandom_range(255)), PW'($urandom));
      checks++;
      if (o_vec !== e_vec) begin
        failures++; $display("FAIL urgent cyc=%0d got=%h exp=%h", i, o_vec, e_vec);
      end
      if (o_en && !o_we && !o_rdy) forced = 1;
    end
    checks++;
    if (!forced || o_rdy !== 1'b1) begin
      failures++; $display("FAIL urgent_recover got forced=%b rdy=%b exp 1 1", forced, o_rdy);
    end
  endtask

  task automatic test_frame_start();
    int cyc = 0;
    int pops = 0;
    tick(1, 0, 0, 1, 0, 19'd3, 24'hABCDEF);
    while (!(q.size() >= 8 && m_inf) && cyc < 40) begin
      tick(1, 0, 0, 0, 0, '0, '0);
      cyc++;
    end
    checks++;
    if (cyc >= 40) begin
      failures++; $display("FAIL fs_setup got timeout qsize=%0d exp >=8 with read in flight", q.size());
    end
    tick(1, 1, 1, 1, 0, 19'h10, 24'h1);
    checks++;
    if (o_vec !== e_vec) begin
      failures++; $display("FAIL fs_pulse got=%h exp=%h", o_vec, e_vec);
    end
    tick(1, 0, 0, 0, 0, '0, '0);
    checks++;
    if (o_pv !== 1'b0 || o_en !== 1'b1 || o_we !== 1'b0 || o_addr !== '0 || o_uf !== 1'b0) begin
      failures++; $display("FAIL fs_restart got pv=%b en=%b we=%b addr=%0d uf=%b exp 0 1 0 0 0", o_pv, o_en, o_we, o_addr, o_uf);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, i >= 6, 0, 0, '0, '0);
      checks++;
      if (o_vec !== e_vec) begin
        failures++; $display("FAIL fs_after cyc=%0d got=%h exp=%h", i, o_vec, e_vec);
      end
      if (i >= 6) pops++;
      if (pops == 4) begin
        checks++;
        if (o_pd !== 24'hABCDEF) begin
          failures++; $display("FAIL fs_coherent got pd=%h exp abcdef", o_pd);
        end
      end
    end
  endtask

  task automatic test_full_frame();
    int start, cyc;
    tick(1, 1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 0, 0, 0, '0, '0);
      checks++;
      if (o_vec !== e_vec) begin
        failures++; $display("FAIL frame_prefill cyc=%0d got=%h exp=%h", i, o_vec, e_vec);
      end
    end
    start = n_pop; cyc = 0;
    while (n_pop - start < int'(N) && cyc < 4 * int'(N)) begin
      tick(1, 0, 1, $urandom_range(1), 0, AW'(256 + $urandom_range(255)), PW'($urandom));
      checks++;
      if (o_vec !== e_vec) begin
        failures++; $display("FAIL frame cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec);
      end
      cyc++;
    end
    checks++;
    if (n_pop - start != int'(N) || underflow !== 1'b0) begin
      failures++; $display("FAIL frame_end got pops=%0d uf=%b exp %0d 0", n_pop - start, underflow, N);
    end
    tick(1, 0, 0, 0, 0, '0, '0);
    checks++;
    if (o_en !== 1'b0 || o_pv !== 1'b0) begin
      failures++; $display("FAIL reads_done got en=%b pv=%b exp 0 0", o_en, o_pv);
    end
  endtask

  task automatic test_underflow();
    tick(1, 0, 1, 0, 0, '0, '0);
    tick(1, 0, 0, 0, 0, '0, '0);
    tick(1, 0, 0, 0, 0, '0, '0);
    checks++;
    if (o_uf !== 1'b1 || o_vec !== e_vec) begin
      failures++; $display("FAIL uf_sticky got uf=%b exp 1", o_uf);
    end
    tick(1, 0, 0, 0, 1, '0, '0);
    tick(1, 0, 0, 0, 0, '0, '0);
    checks++;
    if (o_uf !== 1'b0 || o_vec !== e_vec) begin
      failures++; $display("FAIL uf_clear got uf=%b exp 0", o_uf);
    end
    tick(1, 0, 1, 0, 1, '0, '0);
    tick(1, 0, 0, 0, 0, '0, '0);
    checks++;
    if (o_uf !== 1'b1 || o_vec !== e_vec) begin
      failures++; $display("FAIL uf_set_wins got uf=%b exp 1", o_uf);
    end
  endtask

  task automatic test_mid_reset();
    tick(1, 1, 0, 0, 0, '0, '0);
    tick(1, 0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 12; i++) begin
      tick(1, 0, $urandom_range(1), $urandom_range(1), 0, AW'(256 + $urandom_range(255)), PW'($urandom));
      checks++;
      if (o_vec !== e_vec) begin
        failures++; $display("FAIL mid_activity cyc=%0d got=%h exp=%h", i, o_vec, e_vec);
      end
    end
    tick(0, 0, 1, 1, 0, 19'h120, 24'h77);
    tick(1, 0, 0, 0, 0, '0, '0);
    checks++;
    if (o_pv !== 1'b0 || o_uf !== 1'b0 || o_en !== 1'b1 || o_addr !== '0 || o_vec !== e_vec) begin
      failures++; $display("FAIL mid_reset got=%h exp=%h", o_vec, e_vec);
    end
  endtask

  initial begin
    checks = 0; failures = 0; n_pop = 0;
    m_inf = 0; m_done = 0; m_uf = 0; m_rd = 0; m_inf_val = '0;
    rst_n = 0; frame_start = 0; pix_pop = 0; underflow_clr = 0;
    wr_valid = 0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 512; i++) begin
      gold[i] = PW'($urandom);
      ram[i]  = gold[i];
    end
    @(negedge clk);
    test_reset();
    test_prefill();
    test_write_full();
    test_urgent();
    test_frame_start();
    test_full_frame();
    test_underflow();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_fb_scheduler.md
Name: vga_fb_scheduler

Overview:
Schedules the single-port 24-bit frame-buffer memory between two requesters. The first is the VGA scan-out path, served by a prefetch FIFO. The second is a drawing/writer port with a valid/ready handshake. It sits between the frame-buffer RAM and the VGA timing generator. The timing generator pops one pixel per active display cycle and pulses frame_start once per frame. The scheduler keeps the FIFO ahead of the display and lets writes in whenever the FIFO is not urgent.

Parameters:
H_DISP, 800, active pixels per line
V_DISP, 600, active lines per frame
ADDR_W, 19, frame-buffer address width (must hold H_DISP*V_DISP-1)
PIX_W, 24, pixel width {R[23:16],G[15:8],B[7:0]}
FIFO_DEPTH, 16, prefetch FIFO entries (power of 2)
LOW_WM, 4, occupancy below which display reads take priority over writes

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
frame_start  in  1  one-cycle pulse: restart scan-out at address 0
pix_pop  in  1  consumer takes head pixel this cycle
pix_data  out  PIX_W  FIFO head; 0 when empty
pix_valid  out  1  FIFO non-empty
underflow  out  1  sticky: pop seen while empty
underflow_clr  in  1  clears underflow
wr_valid  in  1  writer request
wr_ready  out  1  write accepted when wr_valid&wr_ready
wr_addr  in  ADDR_W  write address
wr_data  in  PIX_W  write pixel
mem_en  out  1  memory access this cycle
mem_we  out  1  1=write, 0=read (valid when mem_en)
mem_addr  out  ADDR_W  access address
mem_wdata  out  PIX_W  write data
mem_rdata  in  PIX_W  read data, valid exactly 1 cycle after a read

Behaviour:
- Reset: rd_addr=0, reads_done=0, FIFO empty, inflight=0, underflow=0, pix_valid=0, pix_data=0, mem_en=0, mem_we=0. Prefetch begins on the first cycle after reset.
- mem_* outputs and wr_ready are combinational from state and inputs. At most one memory operation is issued per cycle.
- occ = fifo_count + inflight, where inflight=1 if a read was issued last cycle.
- read_ok = ~reads_done & (occ < FIFO_DEPTH).
- urgent = occ < LOW_WM.
- Priority in cycles without frame_start:
  - urgent & read_ok: issue read; wr_ready=0.
  - else if wr_valid: wr_ready=1; issue write (mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data).
  - else if read_ok: issue read.
  - else idle.
- wr_ready does not depend on wr_valid except through the priority above. It is 1 whenever a read is not forced by urgency and frame_start=0.
- Read issue: mem_addr=rd_addr, mem_we=0. rd_addr increments by 1. At H_DISP*V_DISP-1, rd_addr wraps to 0 and reads_done is set. reads_done blocks further reads until frame_start.
- Read return: in the cycle after an issue, mem_rdata is pushed into the FIFO. A slot is always available because occupancy counted the in-flight read.
- Push and pop in the same cycle: count unchanged; FIFO ordering preserved.
- pix_pop while empty: FIFO is unchanged and underflow is set.
- Sticky flag: underflow_clr clears it. If a new underflow and underflow_clr occur in the same cycle, set wins.
- frame_start cycle:
  - FIFO flushed; any in-flight return in that cycle is discarded.
  - rd_addr=0, reads_done=0.
  - No memory op issued; wr_ready=0.
  - pix_pop is ignored, and no underflow is flagged.
  - The first read of the new frame issues on the next cycle.
- Writes never reorder with reads to the same address. A read issued after a write completes sees the new data.
- Reset asserted mid-operation returns to the reset state on the next clock regardless of inflight or FIFO contents.

Test Plan:
- Reset, no pops, wr_valid=0 -> reads at addresses 0..15 on consecutive cycles. Reads then stop with pix_valid=1 and fifo_count=16. pix_data equals mem[0].
- FIFO full, wr_valid=1 held with wr_addr=0x100, wr_data=0xFF0000 -> wr_ready=1 and mem_we=1 the same cycle. Exactly one write is issued per accepted beat.
- Occupancy 3 (<LOW_WM), wr_valid=1 -> read is issued and wr_ready=0. wr_ready returns to 1 once occ>=4.
- pix_pop every cycle for a full frame of 480000 pops with writes interleaved at 50% -> pix_data sequence equals mem[0..479999] in order. underflow stays 0, and reads_done=1 after the last issue.
- frame_start while FIFO half full and a read is in flight -> next cycle pix_valid=0. First new read has mem_addr=0 one cycle after the pulse, and the stale return is not pushed.
- Pop on empty -> underflow=1 and stays 1. Pulse underflow_clr -> 0. Same-cycle underflow_clr plus empty pop -> stays 1.
